barrel_left_shifter_seq: RTL and testbench



---
 rtl/bls_pkg.sv | 19 +
 rtl/barrel_left_shifter_seq_mux2t1.sv | 11 +
 rtl/barrel_left_shifter_seq.sv | 110 +++++++++++
 tb/tb_barrel_left_shifter_seq.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/bls_pkg.sv
// rtl/bls_pkg.sv - shared types and parameter helpers for the sequential left barrel shifter
package bls_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } bls_state_t;

    function automatic int bls_nstages(input int n);
        return $clog2(n);
    endfunction

    // Stage counter width; a single-stage shifter still needs one bit.
    function automatic int bls_kw(input int nstages);
        return (nstages > 1) ? $clog2(nstages) : 1;
    endfunction

endpackage

// File: rtl/barrel_left_shifter_seq_mux2t1.sv
// rtl/barrel_left_shifter_seq_mux2t1.sv - 2:1 mux, one per data bit of the shifter
module Mux2t1 (
    input  logic SELECTOR,
    input  logic A,
    input  logic B,
    output logic Y
);

    assign Y = SELECTOR ? B : A;

endmodule

// File: rtl/barrel_left_shifter_seq.sv
// rtl/barrel_left_shifter_seq.sv - multi-cycle logical left barrel shifter, one 2^k stage per clock
module barrel_left_shifter_seq
    import bls_pkg::*;
#(
    parameter int N       = 8,
    parameter int NStages = 3
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               START,
    input  logic [N-1:0]       IN,
    input  logic [NStages-1:0] AMT,
    output logic               BUSY,
    output logic               DONE,
    output logic [N-1:0]       OUT
);

    localparam int KW = bls_kw(NStages);

    if (NStages != bls_nstages(N)) begin : g_param_check
        $error("barrel_left_shifter_seq: NStages must equal clog2(N)");
    end

    bls_state_t         state, state_n;
    logic [N-1:0]       work, work_n;
    logic [NStages-1:0] amount, amount_n;
    logic [KW-1:0]      k, k_n;
    logic [N-1:0]       out_n;
    logic               busy_n, done_n;

    logic [N-1:0]       stage_b;
    logic [N-1:0]       stage_y;

    // Bit i sees work[i-2^s] for every stage s; k picks which one feeds the mux.
    for (genvar i = 0; i < N; i++) begin : g_bit
        logic [NStages-1:0] cand;
        for (genvar s = 0; s < NStages; s++) begin : g_stage
            if (i >= (1 << s)) begin : g_src
                assign cand[s] = work[i-(1<<s)];
            end else begin : g_zero
                assign cand[s] = 1'b0;
            end
        end
        assign stage_b[i] = cand[k];

        Mux2t1 u_mux (
            .SELECTOR (amount[k]),
            .A        (work[i]),
            .B        (stage_b[i]),
            .Y        (stage_y[i])
        );
    end

    always_comb begin
        state_n  = state;
        work_n   = work;
        amount_n = amount;
        k_n      = k;
        out_n    = OUT;
        busy_n   = 1'b0;
        done_n   = 1'b0;
        case (state)
            IDLE, FINISH: begin
                if (START) begin
                    work_n   = IN;
                    amount_n = AMT;
                    k_n      = '0;
                    busy_n   = 1'b1;
                    state_n  = SHIFT;
                end else begin
                    state_n  = IDLE;
                end
            end
            SHIFT: begin
                work_n = stage_y;
                k_n    = k + 1'b1;
                busy_n = 1'b1;
                if (k == KW'(NStages - 1)) begin
                    out_n   = stage_y;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    k_n     = '0;
                    state_n = FINISH;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            work   <= '0;
            amount <= '0;
            k      <= '0;
            OUT    <= '0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
        end else begin
            state  <= state_n;
            work   <= work_n;
            amount <= amount_n;
            k      <= k_n;
            OUT    <= out_n;
            BUSY   <= busy_n;
            DONE   <= done_n;
        end
    end

endmodule

// File: tb/tb_barrel_left_shifter_seq.sv
// tb/tb_barrel_left_shifter_seq.sv - scoreboard bench for the sequential left barrel shifter
module tb_barrel_left_shifter_seq;

    logic       CLK;
    logic       RST;
    logic       START;
    logic [7:0] IN;
    logic [2:0] AMT;
    logic       BUSY;
    logic       DONE;
    logic [7:0] OUT;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    typedef struct {
        logic [7:0] val;
        int         cyc;
    } exp_t;

    exp_t sb[$];

    barrel_left_shifter_seq #(.N(8), .NStages(3)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .IN    (IN),
        .AMT   (AMT),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .OUT   (OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] model(input logic [7:0] a, input logic [2:0] s);
        int v;
        v = (int'(a) * (1 << s)) % 256;
        return 8'(v);
    endfunction

    always @(negedge CLK) begin
        if (DONE === 1'b1) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: got DONE=1 OUT=0x%0h required no DONE (cycle %0d)", OUT, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out", 32'(OUT), 32'(e.val));
                chk("latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] a, input logic [2:0] s);
        exp_t e;
        e.val = model(a, s);
        e.cyc = cyc + 3;
        sb.push_back(e);
    endtask

    // Issues one operation; caller guarantees the DUT is in IDLE or FINISH.
    task automatic run_op(input logic [7:0] a, input logic [2:0] s);
        IN    = a;
        AMT   = s;
        START = 1'b1;
        step();
        push_exp(a, s);
        START = 1'b0;
        IN    = 8'($urandom);
        AMT   = 3'($urandom);
        step();
        chk("busy_1", 32'(BUSY), 32'd1);
        step();
        chk("busy_2", 32'(BUSY), 32'd1);
        step();
        chk("busy_drop", 32'(BUSY), 32'd0);
    endtask

    initial begin
        RST   = 1'b1;
        START = 1'b0;
        IN    = 8'h00;
        AMT   = 3'd0;
        step();
        step();
        chk("reset_busy", 32'(BUSY), 32'd0);
        chk("reset_done", 32'(DONE), 32'd0);
        chk("reset_out", 32'(OUT), 32'd0);
        RST = 1'b0;
        step();

        run_op(8'b1011_0011, 3'd3);
        chk("basic_out", 32'(OUT), 32'h98);
        step();
        run_op(8'hA5, 3'd0);
        chk("amt0_out", 32'(OUT), 32'hA5);
        step();
        run_op(8'hFF, 3'd7);
        chk("amt7_out", 32'(OUT), 32'h80);
        step();

        IN = 8'h01; AMT = 3'd1; START = 1'b1;
        step();
        push_exp(8'h01, 3'd1);
        IN = 8'hFF; AMT = 3'd4;
        step();
        START = 1'b0;
        step();
        step();
        chk("ignored_start_out", 32'(OUT), 32'h02);
        step();
        step();

        run_op(8'h01, 3'd2);
        chk("b2b_first", 32'(OUT), 32'h04);
        run_op(8'h03, 3'd5);
        chk("b2b_second", 32'(OUT), 32'h60);
        step();

        IN = 8'h0F; AMT = 3'd4; START = 1'b1;
        step();
        START = 1'b0;
        RST   = 1'b1;
        step();
        chk("abort_busy", 32'(BUSY), 32'd0);
        chk("abort_done", 32'(DONE), 32'd0);
        chk("abort_out", 32'(OUT), 32'd0);
        RST = 1'b0;
        repeat (5) step();

        RST = 1'b1; START = 1'b1; IN = 8'hFF; AMT = 3'd1;
        step();
        RST = 1'b0; START = 1'b0;
        step();
        chk("rst_start_busy", 32'(BUSY), 32'd0);
        repeat (4) step();

        for (int a = 0; a < 256; a++) begin
            for (int s = 0; s < 8; s++) begin
                run_op(8'(a), 3'(s));
            end
        end

        for (int n = 0; n < 300; n++) begin
            int gap;
            gap = $urandom_range(0, 2);
            repeat (gap) step();
            run_op(8'($urandom), 3'($urandom));
        end

        repeat (3) step();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
